memory_access: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline. It consumes the EX/MEM pipeline register fields: ALU result as address, latest rs2 value as store data, the load/store flags, funct3, wb_sel, rd label and PC.
- It drives a single-outstanding data-memory req/ack bus with byte enables and performs load extraction with sign/zero extension.
- It produces the MEM forwarding value and the MEM/WB pipeline register consumed by EX forwarding and writeback.
- It stalls the upstream pipeline while a data access is waiting, and it aborts accesses that exceed a timeout.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/load_store_align.sv | 47 ++++
 rtl/memory_access.sv | 152 +++++++++++++++
 tb/tb_memory_access.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM pipeline stage: writeback select, funct3 sizes,
// FSM states and the MEM/WB register payload.
package mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] access-size field
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] value;
        logic [4:0]      rd;
        logic            we;
    } mem_wb_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane logic: store enables and replication, load extraction, alignment check.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_value,
    output logic            misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sign_ext;

    assign lane_b   = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h   = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign sign_ext = ~funct3[2];

    // Anything that is not byte or half is handled as a full word.
    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        load_value = rdata;
        misaligned = 1'b0;
        case (funct3[1:0])
            SZ_B: begin
                be         = 4'b0001 << addr_lo;
                wdata      = {4{store_data[7:0]}};
                load_value = {{24{sign_ext & lane_b[7]}}, lane_b};
            end
            SZ_H: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                load_value = {{16{sign_ext & lane_h[15]}}, lane_h};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: single-outstanding data bus access with timeout, forwarding value
// and the MEM/WB pipeline register.
module memory_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] alu_result_mem_i,
    input  logic [DATA_WIDTH-1:0] latest_rs2_value_mem_i,
    input  logic                  load_store_forward_sel_mem_i,
    input  logic                  reg_write_en_mem_i,
    input  logic                  is_load_instr_mem_i,
    input  logic                  is_store_instr_mem_i,
    input  logic [4:0]            rd_label_mem_i,
    input  logic [1:0]            wb_sel_mem_i,
    input  logic [DATA_WIDTH-1:0] pc_mem_i,
    input  logic [2:0]            funct3_mem_i,
    output logic [DATA_WIDTH-1:0] rd_value_mem_o,
    output logic                  stall_mem_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] rd_value_wb_o,
    output logic [4:0]            rd_label_wb_o,
    output logic                  reg_write_en_wb_o,
    output logic                  misaligned_o,
    output logic                  access_fault_o
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mem_wb_t               wb_q;

    logic                  mem_op;
    logic                  req_c, stall_c, abort_c, mis_c, capture_c;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] align_wdata;
    logic [3:0]            align_be;
    logic                  align_mis;

    assign mem_op     = is_load_instr_mem_i | is_store_instr_mem_i;
    assign store_data = load_store_forward_sel_mem_i ? wb_q.value : latest_rs2_value_mem_i;

    assign rd_value_mem_o = (wb_sel_mem_i == WB_PC4) ? pc_mem_i + DATA_WIDTH'(4)
                                                     : alu_result_mem_i;

    load_store_align u_align (
        .funct3     (funct3_mem_i),
        .addr_lo    (alu_result_mem_i[1:0]),
        .store_data (store_data),
        .rdata      (dmem_rdata_i),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_value (load_value),
        .misaligned (align_mis)
    );

    // Next state, bus handshake and stall; reset masks req/stall combinationally.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        abort_c = 1'b0;
        mis_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (align_mis) begin
                        mis_c = 1'b1;
                    end else begin
                        req_c = 1'b1;
                        if (!dmem_ack_i) begin
                            stall_c = 1'b1;
                            state_d = ST_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (dmem_ack_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    // Final wait cycle: release the pipeline so the faulting op retires.
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (rst_i) begin
            req_c   = 1'b0;
            stall_c = 1'b0;
        end
    end

    assign capture_c = ~stall_c & ~abort_c & ~mis_c;

    assign dmem_req_o   = req_c;
    assign stall_mem_o  = stall_c;
    assign dmem_we_o    = req_c & is_store_instr_mem_i;
    assign dmem_addr_o  = {alu_result_mem_i[DATA_WIDTH-1:2], 2'b00};
    assign dmem_be_o    = is_store_instr_mem_i ? align_be : 4'b1111;
    assign dmem_wdata_o = align_wdata;

    // State, timeout counter, MEM/WB register and event pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            wb_q           <= '0;
            misaligned_o   <= 1'b0;
            access_fault_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            misaligned_o   <= mis_c;
            access_fault_o <= abort_c;
            if (capture_c) begin
                wb_q.value <= (wb_sel_mem_i == WB_MEM) ? load_value : rd_value_mem_o;
                wb_q.rd    <= rd_label_mem_i;
                wb_q.we    <= reg_write_en_mem_i;
            end else begin
                wb_q.rd    <= '0;
                wb_q.we    <= 1'b0;
            end
        end
    end

    assign rd_value_wb_o     = wb_q.value;
    assign rd_label_wb_o     = wb_q.rd;
    assign reg_write_en_wb_o = wb_q.we;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: expected MEM/WB events go into a queue that
// a negedge monitor drains; bus lanes and stall counts are checked inline.
module tb_memory_access;
    import mem_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] alu_result_mem_i, latest_rs2_value_mem_i, pc_mem_i;
    logic        load_store_forward_sel_mem_i, reg_write_en_mem_i;
    logic        is_load_instr_mem_i, is_store_instr_mem_i;
    logic [4:0]  rd_label_mem_i;
    logic [1:0]  wb_sel_mem_i;
    logic [2:0]  funct3_mem_i;
    logic [31:0] rd_value_mem_o, dmem_addr_o, dmem_wdata_o, dmem_rdata_i, rd_value_wb_o;
    logic        stall_mem_o, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [3:0]  dmem_be_o;
    logic [4:0]  rd_label_wb_o;
    logic        reg_write_en_wb_o, misaligned_o, access_fault_o;

    always #5 clk_i = ~clk_i;

    memory_access #(.TIMEOUT_CYCLES(TO), .DATA_WIDTH(32)) dut (
        .clk_i                        (clk_i),
        .rst_i                        (rst_i),
        .alu_result_mem_i             (alu_result_mem_i),
        .latest_rs2_value_mem_i       (latest_rs2_value_mem_i),
        .load_store_forward_sel_mem_i (load_store_forward_sel_mem_i),
        .reg_write_en_mem_i           (reg_write_en_mem_i),
        .is_load_instr_mem_i          (is_load_instr_mem_i),
        .is_store_instr_mem_i         (is_store_instr_mem_i),
        .rd_label_mem_i               (rd_label_mem_i),
        .wb_sel_mem_i                 (wb_sel_mem_i),
        .pc_mem_i                     (pc_mem_i),
        .funct3_mem_i                 (funct3_mem_i),
        .rd_value_mem_o               (rd_value_mem_o),
        .stall_mem_o                  (stall_mem_o),
        .dmem_req_o                   (dmem_req_o),
        .dmem_we_o                    (dmem_we_o),
        .dmem_addr_o                  (dmem_addr_o),
        .dmem_wdata_o                 (dmem_wdata_o),
        .dmem_be_o                    (dmem_be_o),
        .dmem_ack_i                   (dmem_ack_i),
        .dmem_rdata_i                 (dmem_rdata_i),
        .rd_value_wb_o                (rd_value_wb_o),
        .rd_label_wb_o                (rd_label_wb_o),
        .reg_write_en_wb_o            (reg_write_en_wb_o),
        .misaligned_o                 (misaligned_o),
        .access_fault_o               (access_fault_o)
    );

    typedef struct packed {
        logic        we;
        logic        mis;
        logic        flt;
        logic [31:0] val;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push(input logic we, input logic mis, input logic flt,
                        input logic [31:0] val, input logic [4:0] rd);
        exp_t e;
        e.we  = we;
        e.mis = mis;
        e.flt = flt;
        e.val = val;
        e.rd  = rd;
        exp_q.push_back(e);
    endtask

    // Every writeback / misaligned / fault event must match the next queued expectation.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (reg_write_en_wb_o || misaligned_o || access_fault_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: we=%0b mis=%0b flt=%0b val=0x%08h, expected none",
                         reg_write_en_wb_o, misaligned_o, access_fault_o, rd_value_wb_o);
            end else begin
                e = exp_q.pop_front();
                check("wb_we",  32'(reg_write_en_wb_o), 32'(e.we));
                check("wb_mis", 32'(misaligned_o),      32'(e.mis));
                check("wb_flt", 32'(access_fault_o),    32'(e.flt));
                check("wb_rd",  32'(rd_label_wb_o),     32'(e.rd));
                if (e.we) check("wb_val", rd_value_wb_o, e.val);
            end
        end
    end

    task automatic set_instr(input logic ld, input logic st, input logic fwd, input logic rwe,
                             input logic [2:0] f3, input logic [1:0] wbs, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc);
        is_load_instr_mem_i          = ld;
        is_store_instr_mem_i         = st;
        load_store_forward_sel_mem_i = fwd;
        reg_write_en_mem_i           = rwe;
        funct3_mem_i                 = f3;
        wb_sel_mem_i                 = wbs;
        rd_label_mem_i               = rd;
        alu_result_mem_i             = alu;
        latest_rs2_value_mem_i       = rs2;
        pc_mem_i                     = pc;
    endtask

    task automatic nop();
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, WB_ALU, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Holds the current instruction until the stage stops stalling; ack_lat<0 means no ack.
    task automatic run(input int ack_lat, input logic [31:0] rdata,
                       output int req_n, output int stall_n);
        logic done;
        req_n   = 0;
        stall_n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            dmem_ack_i   = (cyc == ack_lat);
            dmem_rdata_i = (cyc == ack_lat) ? rdata : 32'h0;
            #1;
            if (dmem_req_o)  req_n++;
            if (stall_mem_o) stall_n++;
            done = !stall_mem_o;
            @(posedge clk_i);
            #1;
            dmem_ack_i = 1'b0;
            if (done) break;
            check("bubble_we", 32'(reg_write_en_wb_o), 32'h0);
            if (cyc == 39) begin
                n_tests++;
                n_fail++;
                $display("FAIL run_bound: stall still high after 40 cycles, expected release");
            end
        end
        nop();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rq, st;
        rst_i        = 1'b1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
        nop();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_val",   rd_value_wb_o,             32'h0);
        check("rst_rd",    32'(rd_label_wb_o),        32'h0);
        check("rst_we",    32'(reg_write_en_wb_o),    32'h0);
        check("rst_mis",   32'(misaligned_o),         32'h0);
        check("rst_flt",   32'(access_fault_o),       32'h0);
        check("rst_req",   32'(dmem_req_o),           32'h0);
        check("rst_stall", 32'(stall_mem_o),          32'h0);
        rst_i = 1'b0;

        // Plain ALU result
        set_instr(1'b0, 1'b0, 1'b0, 1'b1, F3_W, WB_ALU, 5'd3, 32'h1234_5678, 32'h0, 32'h1000);
        push(1'b1, 1'b0, 1'b0, 32'h1234_5678, 5'd3);
        #1 check("alu_fwd", rd_value_mem_o, 32'h1234_5678);
        run(-1, 32'h0, rq, st);
        check("alu_req", 32'(rq), 32'h0);

        // Zero-wait LW
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_W, WB_MEM, 5'd5, 32'h100, 32'h0, 32'h1004);
        push(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'd5);
        #1 check("lw_be", 32'(dmem_be_o), 32'hF);
        check("lw_we", 32'(dmem_we_o), 32'h0);
        run(0, 32'hDEAD_BEEF, rq, st);
        check("lw_stall", 32'(st), 32'h0);
        check("lw_req",   32'(rq), 32'h1);

        // LB lane 3, ack after 3 cycles
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_B, WB_MEM, 5'd6, 32'h103, 32'h0, 32'h1008);
        push(1'b1, 1'b0, 1'b0, 32'hFFFF_FF80, 5'd6);
        run(3, 32'h80FF_0000, rq, st);
        check("lb_stall", 32'(st), 32'h3);

        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_BU, WB_MEM, 5'd7, 32'h103, 32'h0, 32'h100C);
        push(1'b1, 1'b0, 1'b0, 32'h0000_0080, 5'd7);
        run(1, 32'h80FF_0000, rq, st);
        check("lbu_stall", 32'(st), 32'h1);

        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_H, WB_MEM, 5'd8, 32'h102, 32'h0, 32'h1010);
        push(1'b1, 1'b0, 1'b0, 32'hFFFF_80FF, 5'd8);
        run(0, 32'h80FF_0000, rq, st);

        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_HU, WB_MEM, 5'd9, 32'h100, 32'h0, 32'h1014);
        push(1'b1, 1'b0, 1'b0, 32'h0000_8001, 5'd9);
        run(0, 32'h1234_8001, rq, st);

        // funct3=011 behaves as a word access
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, 3'b011, WB_MEM, 5'd10, 32'h104, 32'h0, 32'h1018);
        push(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 5'd10);
        run(2, 32'hCAFE_F00D, rq, st);

        // SH with load->store forwarding from the WB value 0x5555
        set_instr(1'b0, 1'b0, 1'b0, 1'b1, F3_W, WB_ALU, 5'd11, 32'h5555, 32'h0, 32'h101C);
        push(1'b1, 1'b0, 1'b0, 32'h0000_5555, 5'd11);
        run(-1, 32'h0, rq, st);
        set_instr(1'b0, 1'b1, 1'b1, 1'b0, F3_H, WB_ALU, 5'd0, 32'h202, 32'h1234_ABCD, 32'h1020);
        #1 check("shf_wdata", dmem_wdata_o, 32'h5555_5555);
        check("shf_be", 32'(dmem_be_o), 32'hC);
        run(0, 32'h0, rq, st);

        set_instr(1'b0, 1'b1, 1'b0, 1'b0, F3_H, WB_ALU, 5'd0, 32'h202, 32'h1234_ABCD, 32'h1024);
        #1 check("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
        check("sh_be",   32'(dmem_be_o), 32'hC);
        check("sh_we",   32'(dmem_we_o), 32'h1);
        check("sh_addr", dmem_addr_o,    32'h200);
        run(2, 32'h0, rq, st);
        check("sh_stall", 32'(st), 32'h2);

        set_instr(1'b0, 1'b1, 1'b0, 1'b0, F3_B, WB_ALU, 5'd0, 32'h201, 32'h0000_00EF, 32'h1028);
        #1 check("sb_wdata", dmem_wdata_o, 32'hEFEF_EFEF);
        check("sb_be", 32'(dmem_be_o), 32'h2);
        run(0, 32'h0, rq, st);

        set_instr(1'b0, 1'b1, 1'b0, 1'b0, F3_W, WB_ALU, 5'd0, 32'h204, 32'h89AB_CDEF, 32'h102C);
        #1 check("sw_wdata", dmem_wdata_o, 32'h89AB_CDEF);
        check("sw_be", 32'(dmem_be_o), 32'hF);
        run(0, 32'h0, rq, st);

        // Misaligned accesses: no request, no stall, one-cycle pulse
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_W, WB_MEM, 5'd12, 32'h101, 32'h0, 32'h1030);
        push(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        run(-1, 32'h0, rq, st);
        check("mis_lw_req", 32'(rq), 32'h0);
        check("mis_lw_stall", 32'(st), 32'h0);

        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_H, WB_MEM, 5'd12, 32'h103, 32'h0, 32'h1034);
        push(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        run(-1, 32'h0, rq, st);
        check("mis_lh_req", 32'(rq), 32'h0);

        set_instr(1'b0, 1'b1, 1'b0, 1'b0, F3_W, WB_ALU, 5'd0, 32'h202, 32'h0, 32'h1038);
        push(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        run(-1, 32'h0, rq, st);
        check("mis_sw_req", 32'(rq), 32'h0);

        // Timeout: req for the IDLE cycle plus TO wait cycles, then fault
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_W, WB_MEM, 5'd13, 32'h300, 32'h0, 32'h103C);
        push(1'b0, 1'b0, 1'b1, 32'h0, 5'd0);
        run(-1, 32'h0, rq, st);
        check("to_req_cycles", 32'(rq), 32'(TO + 1));
        check("to_stall_cycles", 32'(st), 32'(TO));
        #1 check("to_req_drop", 32'(dmem_req_o), 32'h0);

        set_instr(1'b0, 1'b0, 1'b0, 1'b1, F3_W, WB_PC4, 5'd14, 32'hBAD, 32'h0, 32'h40);
        push(1'b1, 1'b0, 1'b0, 32'h44, 5'd14);
        #1 check("pc4_fwd", rd_value_mem_o, 32'h44);
        run(-1, 32'h0, rq, st);

        set_instr(1'b0, 1'b0, 1'b0, 1'b1, F3_W, WB_PC4, 5'd15, 32'hBAD, 32'h0, 32'hFFFF_FFFC);
        push(1'b1, 1'b0, 1'b0, 32'h0, 5'd15);
        run(-1, 32'h0, rq, st);

        set_instr(1'b0, 1'b0, 1'b0, 1'b1, F3_W, 2'b11, 5'd16, 32'h77, 32'h0, 32'h2000);
        push(1'b1, 1'b0, 1'b0, 32'h77, 5'd16);
        run(-1, 32'h0, rq, st);

        // Reset asserted while waiting, then a late ack
        set_instr(1'b1, 1'b0, 1'b0, 1'b1, F3_W, WB_MEM, 5'd17, 32'h400, 32'h0, 32'h2004);
        dmem_ack_i = 1'b0;
        @(posedge clk_i);
        #1 check("rw_wait_stall", 32'(stall_mem_o), 32'h1);
        rst_i = 1'b1;
        #1 check("rw_req",   32'(dmem_req_o),  32'h0);
        check("rw_stall", 32'(stall_mem_o), 32'h0);
        @(posedge clk_i);
        #1 check("rw_val", rd_value_wb_o, 32'h0);
        check("rw_we", 32'(reg_write_en_wb_o), 32'h0);
        rst_i = 1'b0;
        nop();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h1111_1111;
        #1 check("late_ack_req", 32'(dmem_req_o), 32'h0);
        @(posedge clk_i);
        #1 dmem_ack_i = 1'b0;
        check("late_ack_stall", 32'(stall_mem_o), 32'h0);

        repeat (3) @(posedge clk_i);
        #1 check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
